// File: rtl/control_sequencer.sv
// Microcode sequencer for the 8-bit bus CPU: walks T0..T4 on the falling edge of i_clk
// and registers the load/output-enable control word for the following rising edge.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// T0 (step 0)  | fetch: PC onto bus, MAR loads (MI|CO)
// T1 (step 1)  | fetch: RAM onto bus, IR loads, PC increments (RO|II|CE)
// T2..T4       | execute steps from the opcode microcode table
// halted       | HLT has been entered; step and control word frozen until reset
module control_sequencer #(
  parameter bit EARLY_END = 1'b1,
  parameter int NUM_STEPS = 5
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_instr,
  input  logic        i_flag_c,
  input  logic        i_flag_z,
  output logic [15:0] o_ctrl,
  output logic [2:0]  o_step,
  output logic        o_halted
);

  localparam logic [2:0]  LAST_STEP = 3'(NUM_STEPS - 1);

  localparam logic [15:0] C_HLT = 16'h8000;
  localparam logic [15:0] C_MI  = 16'h4000;
  localparam logic [15:0] C_RI  = 16'h2000;
  localparam logic [15:0] C_RO  = 16'h1000;
  localparam logic [15:0] C_IO  = 16'h0800;
  localparam logic [15:0] C_II  = 16'h0400;
  localparam logic [15:0] C_AI  = 16'h0200;
  localparam logic [15:0] C_AO  = 16'h0100;
  localparam logic [15:0] C_EO  = 16'h0080;
  localparam logic [15:0] C_SU  = 16'h0040;
  localparam logic [15:0] C_BI  = 16'h0020;
  localparam logic [15:0] C_OI  = 16'h0010;
  localparam logic [15:0] C_CE  = 16'h0008;
  localparam logic [15:0] C_CO  = 16'h0004;
  localparam logic [15:0] C_J   = 16'h0002;
  localparam logic [15:0] C_FI  = 16'h0001;

  localparam logic [15:0] RESET_WORD = C_MI | C_CO;

  function automatic logic [15:0] decode(input logic [2:0] step, input logic [3:0] op,
                                         input logic flag_c, input logic flag_z);
    logic [15:0] w;
    w = 16'h0000;
    case (step)
      3'd0: w = C_MI | C_CO;
      3'd1: w = C_RO | C_II | C_CE;
      3'd2: begin
        case (op)
          4'b0001, 4'b0010, 4'b0011, 4'b0100: w = C_IO | C_MI;
          4'b0101: w = C_IO | C_AI;
          4'b0110: w = C_IO | C_J;
          4'b0111: w = flag_c ? (C_IO | C_J) : 16'h0000;
          4'b1000: w = flag_z ? (C_IO | C_J) : 16'h0000;
          4'b1110: w = C_AO | C_OI;
          4'b1111: w = C_HLT;
          default: w = 16'h0000;
        endcase
      end
      3'd3: begin
        case (op)
          4'b0001: w = C_RO | C_AI;
          4'b0010, 4'b0011: w = C_RO | C_BI;
          4'b0100: w = C_AO | C_RI;
          default: w = 16'h0000;
        endcase
      end
      3'd4: begin
        case (op)
          4'b0010: w = C_EO | C_AI | C_FI;
          4'b0011: w = C_EO | C_AI | C_SU | C_FI;
          default: w = 16'h0000;
        endcase
      end
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  logic [2:0]  step_inc;
  logic [2:0]  step_nxt;
  logic [15:0] ctrl_nxt;
  logic        halted_nxt;

  // Sequencer state lives on the falling edge so the word is settled before datapath rising edges.
  always_ff @(negedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_step   <= 3'd0;
      o_ctrl   <= RESET_WORD;
      o_halted <= 1'b0;
    end else begin
      o_step   <= step_nxt;
      o_ctrl   <= ctrl_nxt;
      o_halted <= halted_nxt;
    end
  end

  always_comb begin
    step_inc = (o_step == LAST_STEP) ? 3'd0 : o_step + 3'd1;
    step_nxt = step_inc;
    if (EARLY_END && (step_inc >= 3'd2) &&
        (decode(step_inc, i_instr, i_flag_c, i_flag_z) == 16'h0000))
      step_nxt = 3'd0;
    if (o_halted)
      step_nxt = o_step;
  end

  always_comb begin
    ctrl_nxt   = o_halted ? o_ctrl : decode(step_nxt, i_instr, i_flag_c, i_flag_z);
    halted_nxt = o_halted | ctrl_nxt[15];
  end

endmodule
